// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, branch redirect,
// and the valid/ready instruction handoff with decoded IR fields.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [5:0]  opa;
  logic [5:0]  funca;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        fetch_err;

  // master: the fetch unit; slave: memory + decode + branch side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_pc, opa, funca, rs, rt, rd, imm,
    output fetch_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_pc, opa, funca, rs, rt, rd, imm,
    input  fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, IR capture,
// valid/ready delivery to decode, branch redirect and sticky timeout fault.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [31:0]     redir_pc;

  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Outputs are registered: each branch sets the values the next state presents.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
        cnt_d   = '0;
      end
      REQ: begin
        if (bus.imem_ack) begin
          ir_d      = bus.imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          req_d     = 1'b0;
          valid_d   = 1'b1;
          state_d   = VALID;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      VALID: begin
        if (bus.inst_ready) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides any same-cycle ack, ready or timeout decision above.
    if (bus.redirect && (state_q != ERR)) begin
      pc_d      = redir_pc;
      addr_d    = redir_pc;
      req_d     = 1'b1;
      valid_d   = 1'b0;
      cnt_d     = '0;
      ir_d      = ir_q;
      inst_pc_d = inst_pc_q;
      err_d     = err_q;
      state_d   = REQ;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.opa        = ir_q[31:26];
  assign bus.rs         = ir_q[25:21];
  assign bus.rt         = ir_q[20:16];
  assign bus.rd         = ir_q[15:11];
  assign bus.imm        = ir_q[15:0];
  assign bus.funca      = ir_q[5:0];
  assign bus.fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of fetched words checked at
// delivery, plus redirect, timeout, PC wrap and async reset scenarios.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_unit_if ba ();
  instr_fetch_unit_if bb ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ba)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bb)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // A presents one word with an ack this cycle; expectation goes to the scoreboard
  task automatic mem_ack_a(input logic [31:0] word);
    sbq.push_back('{pc: exp_pc, word: word});
    ba.imem_ack   = 1'b1;
    ba.imem_rdata = word;
    exp_pc        = exp_pc + 32'd4;
    @(negedge clk);
    ba.imem_ack   = 1'b0;
    ba.imem_rdata = '0;
  endtask

  task automatic check_inst(input string tag);
    exp_t e;
    logic [31:0] w;
    n_vec++;
    assert (sbq.size() != 0) else begin
      n_err++;
      $error("FAIL %s: got empty scoreboard expected pending entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      w = e.word;
      chk({tag, "_valid"}, 32'(ba.inst_valid), 32'd1);
      chk({tag, "_pc"},    ba.inst_pc,         e.pc);
      chk({tag, "_opa"},   32'(ba.opa),        32'(w[31:26]));
      chk({tag, "_rs"},    32'(ba.rs),         32'(w[25:21]));
      chk({tag, "_rt"},    32'(ba.rt),         32'(w[20:16]));
      chk({tag, "_rd"},    32'(ba.rd),         32'(w[15:11]));
      chk({tag, "_imm"},   32'(ba.imm),        32'(w[15:0]));
      chk({tag, "_funca"}, 32'(ba.funca),      32'(w[5:0]));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ba.imem_ack    = 1'b0; ba.imem_rdata  = '0;
    ba.redirect    = 1'b0; ba.redirect_pc = '0;
    ba.inst_ready  = 1'b0;
    bb.imem_ack    = 1'b0; bb.imem_rdata  = '0;
    bb.redirect    = 1'b0; bb.redirect_pc = '0;
    bb.inst_ready  = 1'b0;
    exp_pc         = 32'h0000_0000;

    repeat (2) @(negedge clk);
    chk("rst_req",   32'(ba.imem_req),   32'd0);
    chk("rst_addr",  ba.imem_addr,       32'd0);
    chk("rst_valid", 32'(ba.inst_valid), 32'd0);
    chk("rst_err",   32'(ba.fetch_err),  32'd0);
    chk("rst_ipc",   ba.inst_pc,         32'd0);
    chk("rst_imm",   32'(ba.imm),        32'd0);

    // Release: IDLE for one cycle, request visible in the second
    rst_n = 1'b1;
    chk("idle_req", 32'(ba.imem_req), 32'd0);
    @(negedge clk);
    chk("req0",  32'(ba.imem_req), 32'd1);
    chk("addr0", ba.imem_addr,     exp_pc);

    mem_ack_a(32'h2001_0005);
    check_inst("i0");
    chk("i0_req_low", 32'(ba.imem_req), 32'd0);

    ba.inst_ready = 1'b1;
    @(negedge clk);
    ba.inst_ready = 1'b0;
    chk("req1_valid", 32'(ba.inst_valid), 32'd0);
    chk("req1",       32'(ba.imem_req),   32'd1);
    chk("addr1",      ba.imem_addr,       exp_pc);

    mem_ack_a(32'h0022_1820);
    check_inst("i1");

    // Decode stalls: instruction held, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ba.inst_valid), 32'd1);
      chk("hold_req",   32'(ba.imem_req),   32'd0);
      chk("hold_funca", 32'(ba.funca),      32'h20);
      chk("hold_rd",    32'(ba.rd),         32'd3);
      chk("hold_ipc",   ba.inst_pc,         32'd4);
    end
    ba.inst_ready = 1'b1;
    @(negedge clk);
    ba.inst_ready = 1'b0;
    chk("req2",  32'(ba.imem_req), 32'd1);
    chk("addr2", ba.imem_addr,     32'd8);

    // Redirect collides with ack: ack data must be dropped
    ba.redirect    = 1'b1;
    ba.redirect_pc = 32'h0000_0103;
    ba.imem_ack    = 1'b1;
    ba.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    ba.redirect    = 1'b0;
    ba.imem_ack    = 1'b0;
    ba.imem_rdata  = '0;
    exp_pc         = 32'h0000_0100;
    chk("redir_req",   32'(ba.imem_req),   32'd1);
    chk("redir_addr",  ba.imem_addr,       32'h100);
    chk("redir_valid", 32'(ba.inst_valid), 32'd0);
    chk("redir_funca", 32'(ba.funca),      32'h20);
    chk("redir_opa",   32'(ba.opa),        32'd0);
    chk("redir_ipc",   ba.inst_pc,         32'd4);

    mem_ack_a(32'h8C43_0010);
    check_inst("i2");

    // Timeout: no ack ever arrives
    ba.inst_ready = 1'b1;
    @(negedge clk);
    ba.inst_ready = 1'b0;
    chk("to_req",  32'(ba.imem_req),  32'd1);
    chk("to_addr", ba.imem_addr,      32'h104);
    chk("to_err0", 32'(ba.fetch_err), 32'd0);
    repeat (15) @(negedge clk);
    chk("to_err15", 32'(ba.fetch_err), 32'd0);
    chk("to_req15", 32'(ba.imem_req),  32'd1);
    @(negedge clk);
    chk("to_err16",   32'(ba.fetch_err),  32'd1);
    chk("to_req16",   32'(ba.imem_req),   32'd0);
    chk("to_valid16", 32'(ba.inst_valid), 32'd0);

    ba.redirect    = 1'b1;
    ba.redirect_pc = 32'h0000_0200;
    ba.imem_ack    = 1'b1;
    @(negedge clk);
    ba.redirect    = 1'b0;
    ba.imem_ack    = 1'b0;
    chk("err_redir_err", 32'(ba.fetch_err), 32'd1);
    chk("err_redir_req", 32'(ba.imem_req),  32'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(ba.fetch_err), 32'd1);
    chk("b_err_pre",  32'(bb.fetch_err), 32'd1);

    rst_n = 1'b0;
    #1;
    chk("rst2_err",  32'(ba.fetch_err),  32'd0);
    chk("rst2_req",  32'(ba.imem_req),   32'd0);
    chk("rst2_addr", ba.imem_addr,       32'd0);
    chk("rst2_ipc",  ba.inst_pc,         32'd0);
    chk("rst2_opa",  32'(ba.opa),        32'd0);
    chk("rst2_b_err", 32'(bb.fetch_err), 32'd0);

    // B: TIMEOUT=4 boundary
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("b_req",  32'(bb.imem_req), 32'd1);
    chk("b_addr", bb.imem_addr,     32'hFFFF_FFFC);
    repeat (3) @(negedge clk);
    chk("b_to_err3", 32'(bb.fetch_err), 32'd0);
    chk("b_to_req3", 32'(bb.imem_req),  32'd1);
    @(negedge clk);
    chk("b_to_err4", 32'(bb.fetch_err), 32'd1);
    chk("b_to_req4", 32'(bb.imem_req),  32'd0);

    // B: PC wrap, then reset mid-REQ
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("w_req",  32'(bb.imem_req), 32'd1);
    chk("w_addr", bb.imem_addr,     32'hFFFF_FFFC);
    bb.imem_ack   = 1'b1;
    bb.imem_rdata = 32'h3C01_ABCD;
    @(negedge clk);
    bb.imem_ack   = 1'b0;
    bb.imem_rdata = '0;
    chk("w_valid", 32'(bb.inst_valid), 32'd1);
    chk("w_ipc",   bb.inst_pc,         32'hFFFF_FFFC);
    chk("w_opa",   32'(bb.opa),        32'h0F);
    chk("w_rt",    32'(bb.rt),         32'd1);
    chk("w_imm",   32'(bb.imm),        32'hABCD);
    bb.inst_ready = 1'b1;
    @(negedge clk);
    bb.inst_ready = 1'b0;
    chk("w_req2",  32'(bb.imem_req), 32'd1);
    chk("w_addr2", bb.imem_addr,     32'd0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   32'(bb.imem_req),   32'd0);
    chk("ar_addr",  bb.imem_addr,       32'd0);
    chk("ar_valid", 32'(bb.inst_valid), 32'd0);
    chk("ar_ipc",   bb.inst_pc,         32'd0);
    chk("ar_opa",   32'(bb.opa),        32'd0);
    chk("ar_rt",    32'(bb.rt),         32'd0);
    chk("ar_imm",   32'(bb.imm),        32'd0);
    chk("ar_err",   32'(bb.fetch_err),  32'd0);
    chk("ar_sbq",   32'(sbq.size()),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
